// File: rtl/envelope_sequencer_if.sv
// Channel-side bus of the envelope sequencer: enable, per-channel period/trigger
// in, frame phase, tick pulses and per-channel envelope step strobes out.
interface envelope_sequencer_if #(
    parameter int NUM_CH = 4
);
    logic                  enable;
    logic [3*NUM_CH-1:0]   period;
    logic [NUM_CH-1:0]     trigger;
    logic [2:0]            frame_step;
    logic                  len_tick;
    logic                  sweep_tick;
    logic                  env_tick;
    logic [NUM_CH-1:0]     env_step;

    modport master (
        output enable, period, trigger,
        input  frame_step, len_tick, sweep_tick, env_tick, env_step
    );

    modport slave (
        input  enable, period, trigger,
        output frame_step, len_tick, sweep_tick, env_tick, env_step
    );
endinterface

// File: rtl/envelope_sequencer.sv
// Frame sequencer (512 Hz, 8 phases) with length/sweep/envelope ticks and one
// envelope period counter per channel. Define SEQ_DIV_RESYNC_EN to add div_reset.
module envelope_sequencer #(
    parameter int CLK_DIV = 8192,
    parameter int NUM_CH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    envelope_sequencer_if.slave bus
`ifdef SEQ_DIV_RESYNC_EN
    ,
    input  logic                div_reset
`endif
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0]         div_q;
    logic [2:0]               step_q;
    logic [2:0]               step_nxt;
    logic                     div_last;
    logic                     div_clr;
    logic                     frame_edge;
    logic                     env_frame;

    logic                     len_tick_q;
    logic                     sweep_tick_q;
    logic                     env_tick_q;

    logic [NUM_CH-1:0][2:0]   per;
    logic [NUM_CH-1:0][2:0]   cnt_q;
    logic [NUM_CH-1:0][2:0]   cnt_d;
    logic [NUM_CH-1:0]        env_step_q;
    logic [NUM_CH-1:0]        env_step_d;

`ifdef SEQ_DIV_RESYNC_EN
    assign div_clr = div_reset;
`else
    assign div_clr = 1'b0;
`endif

    assign div_last   = (div_q == DIV_W'(CLK_DIV - 1));
    assign step_nxt   = step_q + 3'd1;
    assign frame_edge = bus.enable && div_last && !div_clr;
    assign env_frame  = frame_edge && (step_nxt == 3'd7);
    assign per        = bus.period;

    // Divider and phase counter; a DIV write clears the divider even while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            step_q <= 3'd7;
        end else if (div_clr) begin
            div_q  <= '0;
        end else if (bus.enable) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            if (div_last) begin
                div_q  <= '0;
                step_q <= step_nxt;
            end else begin
                div_q  <= div_q + DIV_W'(1);
            end
        end
    end

    // frame_edge already folds in enable and div_clr, so a disabled cycle clears all ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_tick_q   <= 1'b0;
            sweep_tick_q <= 1'b0;
            env_tick_q   <= 1'b0;
        end else begin
            len_tick_q   <= frame_edge && !step_nxt[0];
            sweep_tick_q <= frame_edge && (step_nxt[1:0] == 2'b10);
            env_tick_q   <= env_frame;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: every output of this block gets a default first, so no path can infer a latch.
            cnt_d[i]      = cnt_q[i];
            env_step_d[i] = 1'b0;
            if (bus.trigger[i]) begin
                cnt_d[i] = per[i];
            end else if (env_frame && (per[i] != 3'd0)) begin
                if (cnt_q[i] == 3'd1) begin
                    env_step_d[i] = 1'b1;
                    cnt_d[i]      = per[i];
                end else if (cnt_q[i] == 3'd0) begin
                    cnt_d[i] = per[i];
                end else begin
                    cnt_d[i] = cnt_q[i] - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the counter array is reset because a stale count would shift the first step after reset.
            cnt_q      <= '0;
            env_step_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            env_step_q <= env_step_d;
        end
    end

    assign bus.frame_step = step_q;
    assign bus.len_tick   = len_tick_q;
    assign bus.sweep_tick = sweep_tick_q;
    assign bus.env_tick   = env_tick_q;
    assign bus.env_step   = env_step_q;

endmodule

// File: tb/tb_envelope_sequencer.sv
// Directed bench for envelope_sequencer with CLK_DIV = 4; outputs sampled on the
// falling edge, inputs driven right after it.
module tb_envelope_sequencer;

    localparam int CLK_DIV = 4;
    localparam int NUM_CH  = 4;

    logic clk;
    logic rst_n;
`ifdef SEQ_DIV_RESYNC_EN
    logic div_reset;
`endif

    envelope_sequencer_if #(.NUM_CH(NUM_CH)) bus ();

    envelope_sequencer #(
        .CLK_DIV (CLK_DIV),
        .NUM_CH  (NUM_CH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef SEQ_DIV_RESYNC_EN
        ,
        .div_reset (div_reset)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // sel 0 waits for len_tick, otherwise for env_tick; a timeout counts as a failure.
    task automatic wait_tick(input int sel, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = (sel == 0) ? bus.len_tick : bus.env_tick;
        end
        if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    int n_len, n_sweep, n_env, n_wrap, n_bad;
    int n_frozen_ticks;
    logic [2:0] prev_step;

    initial begin
        rst_n       = 1'b0;
        bus.enable  = 1'b1;
        bus.period  = '0;
        bus.trigger = '0;
`ifdef SEQ_DIV_RESYNC_EN
        div_reset   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_step",     32'(bus.frame_step), 32'd7);
        check("rst_ticks",    32'({bus.len_tick, bus.sweep_tick, bus.env_tick}), 32'd0);
        check("rst_env_step", 32'(bus.env_step), 32'd0);
        rst_n = 1'b1;

        // First frame edge lands on step 0 after CLK_DIV clocks.
        repeat (3) @(negedge clk);
        check("pre_edge_step", 32'(bus.frame_step), 32'd7);
        check("pre_edge_len",  32'(bus.len_tick),   32'd0);
        @(negedge clk);
        check("edge0_step",  32'(bus.frame_step), 32'd0);
        check("edge0_len",   32'(bus.len_tick),   32'd1);
        check("edge0_sweep", 32'(bus.sweep_tick), 32'd0);
        check("edge0_env",   32'(bus.env_tick),   32'd0);
        @(negedge clk);
        check("edge0_len_1cyc", 32'(bus.len_tick), 32'd0);

        // 32 frame edges in 128 cycles.
        n_len = 0; n_sweep = 0; n_env = 0; n_wrap = 0; n_bad = 0;
        prev_step = bus.frame_step;
        for (int c = 0; c < 32 * CLK_DIV; c++) begin
            @(negedge clk);
            if (bus.len_tick)   n_len++;
            if (bus.sweep_tick) n_sweep++;
            if (bus.env_tick)   n_env++;
            if (prev_step == 3'd7 && bus.frame_step == 3'd0) n_wrap++;
            if (bus.len_tick && bus.frame_step[0]) n_bad++;
            if (bus.sweep_tick && bus.frame_step != 3'd2 && bus.frame_step != 3'd6) n_bad++;
            if (bus.env_tick && bus.frame_step != 3'd7) n_bad++;
            prev_step = bus.frame_step;
        end
        check("run_len_count",   32'(n_len),   32'd16);
        check("run_sweep_count", 32'(n_sweep), 32'd8);
        check("run_env_count",   32'(n_env),   32'd4);
        check("run_wraps",       32'(n_wrap),  32'd4);
        check("run_tick_phase",  32'(n_bad),   32'd0);

        // ch0 period 3 steps on every 3rd env_tick; ch1 period 0 never steps.
        bus.period[2:0] = 3'd3;
        bus.period[5:3] = 3'd0;
        bus.trigger     = 4'b0011;
        @(negedge clk);
        bus.trigger     = '0;
        for (int k = 1; k <= 9; k++) begin
            wait_tick(1, "ch0_env");
            check($sformatf("ch0_step_env%0d", k), 32'(bus.env_step[0]), (k % 3 == 0) ? 32'd1 : 32'd0);
            check($sformatf("ch1_step_env%0d", k), 32'(bus.env_step[1]), 32'd0);
        end
        @(negedge clk);
        check("ch0_step_1cyc", 32'(bus.env_step[0]), 32'd0);

        // Trigger on ch2 coinciding with an env frame while cnt[2] = 1 wins.
        bus.period[8:6] = 3'd2;
        bus.trigger[2]  = 1'b1;
        @(negedge clk);
        bus.trigger[2]  = 1'b0;
        wait_tick(1, "ch2_env_a");
        check("ch2_step_a", 32'(bus.env_step[2]), 32'd0);
        repeat (4 * 8 - 1) @(negedge clk);
        bus.trigger[2] = 1'b1;
        @(negedge clk);
        bus.trigger[2] = 1'b0;
        check("ch2_coincide_env_tick", 32'(bus.env_tick),    32'd1);
        check("ch2_coincide_no_step",  32'(bus.env_step[2]), 32'd0);
        wait_tick(1, "ch2_env_b");
        check("ch2_step_b", 32'(bus.env_step[2]), 32'd0);
        wait_tick(1, "ch2_env_c");
        check("ch2_step_c", 32'(bus.env_step[2]), 32'd1);

        // Freeze at step 7 / divider 0 for 10 cycles; a trigger still loads ch3.
        wait_tick(1, "freeze_env");
        bus.enable       = 1'b0;
        bus.period[11:9] = 3'd1;
        bus.trigger[3]   = 1'b1;
        n_frozen_ticks   = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.trigger[3] = 1'b0;
            if (bus.len_tick || bus.sweep_tick || bus.env_tick || (bus.env_step != '0)) n_frozen_ticks++;
        end
        check("frozen_no_ticks", 32'(n_frozen_ticks),  32'd0);
        check("frozen_step",     32'(bus.frame_step), 32'd7);
        bus.enable = 1'b1;
        repeat (3) @(negedge clk);
        check("resume_pre_step", 32'(bus.frame_step), 32'd7);
        @(negedge clk);
        check("resume_step", 32'(bus.frame_step), 32'd0);
        check("resume_len",  32'(bus.len_tick),   32'd1);
        wait_tick(1, "ch3_env");
        check("ch3_trigger_while_disabled", 32'(bus.env_step[3]), 32'd1);

        // Asynchronous reset mid-count clears outputs before any clock edge.
        wait_tick(0, "arst_len");
        #2 rst_n = 1'b0;
        #1;
        check("arst_step", 32'(bus.frame_step), 32'd7);
        check("arst_ticks", 32'({bus.len_tick, bus.sweep_tick, bus.env_tick}), 32'd0);
        check("arst_env_step", 32'(bus.env_step), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SEQ_DIV_RESYNC_EN
        // div_reset at divider = CLK_DIV-1 cancels that frame edge.
        wait_tick(1, "resync_env");
        repeat (CLK_DIV - 1) @(negedge clk);
        div_reset = 1'b1;
        @(negedge clk);
        div_reset = 1'b0;
        check("resync_no_edge_step", 32'(bus.frame_step), 32'd7);
        check("resync_no_edge_len",  32'(bus.len_tick),   32'd0);
        repeat (CLK_DIV - 1) @(negedge clk);
        check("resync_pre_step", 32'(bus.frame_step), 32'd7);
        @(negedge clk);
        check("resync_step", 32'(bus.frame_step), 32'd0);
        check("resync_len",  32'(bus.len_tick),   32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
